// File: rtl/ppe_pkt_pkg.sv
// Shared router packet definitions for the PPE receive path: field
// positions, opcodes, default widths and the weight-row FSM states.
package ppe_pkt_pkg;

  localparam int PKT_WIDTH    = 33;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ROW_LEN      = 5;

  // Packet layout: {addr[32:29], opcode[28:25], data[24:0]}
  localparam int ADDR_HI   = 32;
  localparam int ADDR_LO   = 29;
  localparam int OPCODE_HI = 28;
  localparam int OPCODE_LO = 25;
  localparam int DATA_HI   = 24;
  localparam int DATA_LO   = 0;

  localparam logic [3:0] OP_WEIGHT        = 4'd0;
  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

  // Router address of the ifmap memory.
  localparam logic [3:0] IMEM_ID = 4'd11;

  // Weight-row reassembly states.
  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    LOADED  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ppe_byp_buf.sv
// One-entry valid/ready register that forwards non-weight packets to the
// PPE ifmap/control logic. A new entry may be loaded on the same edge the
// old one is consumed, so back-to-back packets stream at full rate.
module ppe_byp_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Entry register: load on push, empty on pop, hold while stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ppe_weight_rx.sv
// PPE weight receive stage: reassembles a 5-weight filter row from two
// OP_WEIGHT packets (w0..w2, then w3..w4) and forwards every other packet
// through a one-entry bypass buffer.
// Optional build macro PPE_WEIGHT_RX_ADDR_CHECK_EN: drop packets whose
// address differs from PE_ID and pulse err_misroute for one cycle.
module ppe_weight_rx #(
  parameter int PE_ID        = 5,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ROW_LEN      = 5,
  parameter int PKT_WIDTH    = 33
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  input  logic [PKT_WIDTH-1:0]            pkt_data,
  output logic [ROW_LEN*WEIGHT_WIDTH-1:0] weights_out,
  output logic                            weights_ready,
  output logic [7:0]                      row_loads,
  output logic                            byp_valid,
  input  logic                            byp_ready,
  output logic [PKT_WIDTH-1:0]            byp_data,
  output logic                            err_misroute
);

  import ppe_pkt_pkg::*;

  // The LO packet carries three weights, the HI packet the remainder.
  localparam int LO_BITS = 3 * WEIGHT_WIDTH;
  localparam int HI_BITS = (ROW_LEN - 3) * WEIGHT_WIDTH;

`ifdef PPE_WEIGHT_RX_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  rx_state_e                       state_q, state_d;
  logic [ROW_LEN*WEIGHT_WIDTH-1:0] weights_q;
  logic [7:0]                      row_loads_q;
  logic                            is_weight;
  logic                            accept;
  logic                            misroute;
  logic                            wt_accept;
  logic                            byp_push;
  logic                            byp_in_ready;
  logic                            lo_wr;
  logic                            hi_wr;

  assign is_weight = (pkt_data[OPCODE_HI:OPCODE_LO] == OP_WEIGHT);

  // Weight packets never block; others wait for room in the bypass entry.
  assign pkt_ready = is_weight || byp_in_ready;
  assign accept    = pkt_valid && pkt_ready;

  // Misaddressed packets are consumed but have no other effect.
  assign misroute  = ADDR_CHECK && accept &&
                     (pkt_data[ADDR_HI:ADDR_LO] != 4'(PE_ID));
  assign wt_accept = accept && !misroute && is_weight;
  assign byp_push  = accept && !misroute && !is_weight;

  // State register for row reassembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_LO;
    else     state_q <= state_d;
  end

  // Next state and weight-half write strobes.
  // NOTE: every signal driven here gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    lo_wr   = 1'b0;
    hi_wr   = 1'b0;
    case (state_q)
      WAIT_LO: if (wt_accept) begin lo_wr = 1'b1; state_d = WAIT_HI; end
      WAIT_HI: if (wt_accept) begin hi_wr = 1'b1; state_d = LOADED;  end
      LOADED:  if (wt_accept) begin lo_wr = 1'b1; state_d = WAIT_HI; end
      default: state_d = WAIT_LO;
    endcase
  end

  // Weight row register and completed-row counter.
  // NOTE: the row register is reset because it is a visible output
  // required to read zero after reset, not because storage needs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights_q   <= '0;
      row_loads_q <= '0;
    end else begin
      if (lo_wr) weights_q[LO_BITS-1:0] <= pkt_data[LO_BITS-1:0];
      if (hi_wr) begin
        weights_q[LO_BITS +: HI_BITS] <= pkt_data[HI_BITS-1:0];
        row_loads_q                   <= row_loads_q + 8'd1;
      end
    end
  end

  assign weights_out   = weights_q;
  assign weights_ready = (state_q == LOADED);
  assign row_loads     = row_loads_q;

  ppe_byp_buf #(
    .WIDTH (PKT_WIDTH)
  ) u_byp_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (byp_push),
    .in_ready  (byp_in_ready),
    .in_data   (pkt_data),
    .out_valid (byp_valid),
    .out_ready (byp_ready),
    .out_data  (byp_data)
  );

`ifdef PPE_WEIGHT_RX_ADDR_CHECK_EN
  logic err_q;

  // One-cycle error pulse following each dropped misaddressed packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= misroute;
  end

  assign err_misroute = err_q;
`else
  assign err_misroute = 1'b0;
`endif

endmodule
